// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with wrap/saturate, terminal count and 7-seg glyphs
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             dir,
  output logic [6:0]       segment,
  output logic             digit,
  output logic [6:0]       hex_seg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MAX_VAL);
  localparam logic [6:0]       SEG_U = 7'b0111110;
  localparam logic [6:0]       SEG_D = 7'b1011110;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt, dir_nxt;
  logic [6:0]       seg_nxt;

  always_comb begin
    out_nxt   = out;
    tc_nxt    = 1'b0;
    dir_nxt   = dir;
    state_nxt = state;
    if (load) begin
      out_nxt = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      dir_nxt   = up;
      state_nxt = up ? S_UP : S_DOWN;
      if (up) begin
        if (out >= MAX) begin
          tc_nxt  = 1'b1;
          out_nxt = SATURATE ? out : '0;
        end else begin
          out_nxt = out + 1'b1;
        end
      end else begin
        if (out == '0) begin
          tc_nxt  = 1'b1;
          out_nxt = SATURATE ? out : MAX;
        end else begin
          out_nxt = out - 1'b1;
        end
      end
    end
  end

  // Glyph follows the next state so segment and digit move on the same edge.
  always_comb begin
    seg_nxt = 7'b0000000;
    case (state_nxt)
      S_UP:    seg_nxt = SEG_U;
      S_DOWN:  seg_nxt = SEG_D;
      default: seg_nxt = 7'b0000000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      out     <= '0;
      tc      <= 1'b0;
      dir     <= 1'b0;
      state   <= S_IDLE;
      segment <= 7'b0000000;
      digit   <= 1'b0;
    end else begin
      out     <= out_nxt;
      tc      <= tc_nxt;
      dir     <= dir_nxt;
      state   <= state_nxt;
      segment <= seg_nxt;
      digit   <= |seg_nxt;
    end
  end

  always_comb begin
    hex_seg = 7'h00;
    case (out[3:0])
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
      default: hex_seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param (hex, decade and saturating variants)
module tb_updown_counter_param;

  logic       CLK;
  logic       rst, en, up, load;
  logic [3:0] load_val;

  logic [3:0] out_h, out_d, out_s;
  logic       tc_h, tc_d, tc_s, dir_h, dir_d, dir_s, dg_h, dg_d, dg_s;
  logic [6:0] seg_h, seg_d, seg_s, hx_h, hx_d, hx_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] o;
    logic       t;
    logic       d;
    logic [6:0] s;
    logic       g;
    logic [6:0] h;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model state per instance: 0 = hex/wrap, 1 = decade/wrap, 2 = decade/saturate
  int mo [3];
  bit mt [3];
  bit md [3];
  int ms [3];
  int mx [3]  = '{15, 9, 9};
  bit sat [3] = '{1'b0, 1'b0, 1'b1};

  updown_counter_param dut_h (
    .CLK(CLK), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_h), .tc(tc_h), .dir(dir_h), .segment(seg_h), .digit(dg_h), .hex_seg(hx_h)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_d (
    .CLK(CLK), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_d), .tc(tc_d), .dir(dir_d), .segment(seg_d), .digit(dg_d), .hex_seg(hx_d)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
    .CLK(CLK), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out_s), .tc(tc_s), .dir(dir_s), .segment(seg_s), .digit(dg_s), .hex_seg(hx_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.o = 4'(mo[i]);
    e.t = mt[i];
    e.d = md[i];
    e.s = (ms[i] == 1) ? 7'b0111110 : (ms[i] == 2) ? 7'b1011110 : 7'b0000000;
    e.g = (ms[i] != 0);
    e.h = hex_tab[mo[i] % 16];
    return e;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit e, input bit u, input int lv);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mo[i] = 0; mt[i] = 0; md[i] = 0; ms[i] = 0;
      end else if (l) begin
        mo[i] = (lv > mx[i]) ? mx[i] : lv;
        mt[i] = 0;
      end else if (e) begin
        md[i] = u;
        ms[i] = u ? 1 : 2;
        if (u && mo[i] == mx[i]) begin
          mt[i] = 1;
          if (!sat[i]) mo[i] = 0;
        end else if (!u && mo[i] == 0) begin
          mt[i] = 1;
          if (!sat[i]) mo[i] = mx[i];
        end else begin
          mt[i] = 0;
          mo[i] = u ? mo[i] + 1 : mo[i] - 1;
        end
      end else begin
        mt[i] = 0;
      end
      exp_q.push_back(model_out(i));
    end
  endtask

  task automatic compare_one(input string nm, input logic [3:0] o, input logic t, input logic d,
                             input logic [6:0] s, input logic g, input logic [6:0] h);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({nm, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({nm, "_out"}, 32'(o), 32'(e.o));
    check({nm, "_tc"}, 32'(t), 32'(e.t));
    check({nm, "_dir"}, 32'(d), 32'(e.d));
    check({nm, "_segment"}, 32'(s), 32'(e.s));
    check({nm, "_digit"}, 32'(g), 32'(e.g));
    check({nm, "_hex_seg"}, 32'(h), 32'(e.h));
  endtask

  task automatic drive(input bit r, input bit l, input bit e, input bit u, input logic [3:0] lv);
    rst = r; load = l; en = e; up = u; load_val = lv;
    model_step(r, l, e, u, int'(lv));
    @(posedge CLK);
    #1;
    compare_one("hex", out_h, tc_h, dir_h, seg_h, dg_h, hx_h);
    compare_one("dec", out_d, tc_d, dir_d, seg_d, dg_d, hx_d);
    compare_one("sat", out_s, tc_s, dir_s, seg_s, dg_s, hx_s);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = 4'd0;
    @(posedge CLK);
    #1;

    drive(1, 0, 0, 0, 0);
    check("reset_out", 32'(out_h), 32'd0);
    check("reset_segment", 32'(seg_h), 32'd0);
    check("reset_digit", 32'(dg_h), 32'd0);

    // full hex run through the wrap
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, 1, 0);
      check($sformatf("hex_run_out_%0d", i), 32'(out_h), 32'((i + 1) % 16));
      check($sformatf("hex_run_tc_%0d", i), 32'(tc_h), 32'(i == 15));
    end
    check("hex_run_segment", 32'(seg_h), 32'h3E);
    check("hex_run_dir", 32'(dir_h), 32'd1);

    // decade counting down from 0 wraps to 9
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    check("dec_wrap_out", 32'(out_d), 32'd9);
    check("dec_wrap_tc", 32'(tc_d), 32'd1);
    check("dec_wrap_hex", 32'(hx_d), 32'h6F);
    check("dec_wrap_segment", 32'(seg_d), 32'h5E);
    drive(0, 0, 1, 0, 0);
    check("dec_down_8", 32'(out_d), 32'd8);
    drive(0, 0, 1, 0, 0);
    check("dec_down_7", 32'(out_d), 32'd7);

    // saturate at the top bound, then step back down
    drive(0, 1, 0, 0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0);
      check($sformatf("sat_hold_out_%0d", i), 32'(out_s), 32'd9);
      check($sformatf("sat_hold_tc_%0d", i), 32'(tc_s), 32'(i != 0));
    end
    drive(0, 0, 1, 0, 0);
    check("sat_release_out", 32'(out_s), 32'd8);
    check("sat_release_tc", 32'(tc_s), 32'd0);

    // load beats en and clamps; issued right after reset the FSM stays idle
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 4'd12);
    check("load_clamp_dec", 32'(out_d), 32'd9);
    check("load_noclamp_hex", 32'(out_h), 32'd12);
    check("load_idle_digit", 32'(dg_d), 32'd0);
    check("load_idle_segment", 32'(seg_d), 32'd0);

    // reset mid-count overrides load and en, then idle cycles hold
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0);
    check("pre_reset_out", 32'(out_h), 32'd5);
    drive(1, 1, 1, 1, 4'd3);
    check("mid_reset_out", 32'(out_h), 32'd0);
    check("mid_reset_dir", 32'(dir_h), 32'd0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
    check("idle_hold_out", 32'(out_h), 32'd0);

    // direction flip every cycle from 3
    drive(0, 1, 0, 0, 4'd3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2) == 0, 0);
      check($sformatf("flip_out_%0d", i), 32'(out_h), ((i % 2) == 0) ? 32'd4 : 32'd3);
      check($sformatf("flip_seg_%0d", i), 32'(seg_h), ((i % 2) == 0) ? 32'h3E : 32'h5E);
    end

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter with synchronous load, count enable, selectable wrap or saturate at a programmable modulus, and a registered terminal-count flag. It drives a seven-segment direction glyph ("U" or "d") with a digit-enable, plus a hex decode of the low count nibble. It is the board-level counter/display block for lab designs needing decade, hex or wider counts.

Parameters:
WIDTH, 4, counter width in bits; legal range is WIDTH >= 4.
MAX_VAL, 2**WIDTH-1, top count value; count range is 0..MAX_VAL; legal range is 1 <= MAX_VAL <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
CLK  in  1  clock; all state updates on its rising edge
rst  in  1  reset; synchronous, active-high
en  in  1  count enable; one step per cycle while high
up  in  1  step direction; 1 = increment, 0 = decrement
load  in  1  synchronous load of load_val
load_val  in  WIDTH  load value
out  out  WIDTH  registered count
tc  out  1  registered terminal-count flag
dir  out  1  registered last step direction; 1 = up
segment  out  7  registered direction glyph; active-high; bit0=a … bit6=g
digit  out  1  registered OR of the segment bits; enables the glyph digit
hex_seg  out  7  combinational hex decode of out[3:0]; active-high; same bit order as segment

Behaviour:
- Priority at each rising edge of CLK: rst, then load, then en, then hold.
- Reset (rst=1): out=0, tc=0, dir=0, segment=7'b0000000, digit=0, FSM=IDLE. Applies mid-count and overrides load and en in the same cycle.
- FSM states and glyphs:
  - IDLE: segment 7'b0000000.
  - UP: glyph "U", segment 7'b0111110.
  - DOWN: glyph "d", segment 7'b1011110.
- FSM transitions:
  - Any enabled step with up=1 goes to UP; with up=0 goes to DOWN.
  - load and idle cycles (en=0) leave the FSM unchanged.
  - IDLE is reachable only through reset.
- dir is updated only on an enabled step. In IDLE it stays 0.
- digit is the registered value of |segment, computed from the next-state segment so it updates on the same edge as segment. It is 0 only in IDLE.
- Load (load=1):
  - out = min(load_val, MAX_VAL); an out-of-range value is clamped.
  - tc = 0.
  - dir, FSM and segment are unchanged.
  - en is ignored that cycle.
- Enabled step (en=1, load=0), latency 1 cycle. Arithmetic is on WIDTH bits and never exceeds MAX_VAL.
  - Up, out < MAX_VAL: out+1, tc=0.
  - Up, out == MAX_VAL: out=0 if SATURATE=0, unchanged if SATURATE=1; tc=1.
  - Down, out > 0: out-1, tc=0.
  - Down, out == 0: out=MAX_VAL if SATURATE=0, unchanged if SATURATE=1; tc=1.
- tc is high for exactly the cycle following each bound event. It stays high on consecutive cycles while stepping against a bound in saturate mode.
- Hold (en=0, load=0): out, dir, FSM and segment keep their values; tc = 0.
- A direction change on consecutive cycles takes effect immediately, with no extra cycle.
- hex_seg decodes 0–F in active-high form, a..g order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Values are 7-bit hex with bit0=a. For WIDTH > 4, hex_seg shows the low nibble only.
- The state holds only legal values; no X propagates after the first reset.

Test Plan:
- Defaults (WIDTH=4, MAX_VAL=15, SATURATE=0): rst 1 cycle, then en=1, up=1 for 17 cycles. Required: out runs 1..15, 0, 1; tc=1 only on the cycle out=0; segment=0111110; digit=1; dir=1.
- Decade (MAX_VAL=9): out=0, en=1, up=0. Required: out=9 with tc=1, then 8, 7 …; segment=1011110; hex_seg=6F when out=9.
- Saturate (MAX_VAL=9, SATURATE=1): load 8, then up for 3 cycles. Required: out=9, 9, 9; tc=0, 1, 1; returning to down gives out=8, tc=0.
- Load priority: load=1, load_val=12, en=1, up=1 with MAX_VAL=9. Required: out=9 (clamped), tc=0, FSM/segment unchanged; IDLE with digit=0 if issued directly after reset.
- Reset mid-count: out=5 in UP; rst=1 together with load=1 and en=1. Required next cycle: out=0, tc=0, dir=0, segment=0000000, digit=0. With rst=0 and en=0 for 3 cycles, all outputs hold.
- Direction flip: alternate up=1/0 each cycle from out=3. Required: out 4, 3, 4, 3; segment toggles 0111110/1011110 each cycle; tc stays 0.
